// File: rtl/rs422_tx_arb.sv
// Two-source RS-422 transmit arbiter: grants one frame at a time to the reply (ack) or
// science source, paces bytes into the UART, and enforces an idle gap between frames.
`timescale 1ns/1ps
module rs422_tx_arb #(
  parameter int FRAME_LEN   = 268,
  parameter int GAP_CYC     = 2400,
  parameter int TIMEOUT_CYC = 12000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ack_req,
  input  logic       ack_valid,
  input  logic       ack_last,
  input  logic [7:0] ack_data,
  input  logic       sci_req,
  input  logic       sci_valid,
  input  logic [7:0] sci_data,
  output logic       ack_gnt,
  output logic       sci_gnt,
  output logic       ack_rd,
  output logic       sci_rd,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic       tx_busy,
  output logic       frame_done,
  output logic       timeout_err,
  output logic       reply
);

  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam int TO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WAITB = 2'd1;
  localparam logic [1:0] SEND  = 2'd2;
  localparam logic [1:0] GAP   = 2'd3;

  localparam logic LW_SCI = 1'b0;
  localparam logic LW_ACK = 1'b1;

  logic [1:0]       state;
  logic             last_winner;
  logic [8:0]       byte_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic             send_first;
  logic             last_flag;

  logic       src_valid;
  logic [7:0] src_data;
  logic       ack_wins;
  logic       frame_end;

  // Round-robin only breaks ties; a lone request always wins.
  always_comb begin
    src_valid = ack_gnt ? ack_valid : sci_valid;
    src_data  = ack_gnt ? ack_data  : sci_data;
    ack_wins  = ack_req && !(sci_req && (last_winner == LW_ACK));
    frame_end = ack_gnt ? last_flag : (byte_cnt == 9'(FRAME_LEN));
  end

  assign reply = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last_winner <= LW_SCI;
      byte_cnt    <= '0;
      to_cnt      <= '0;
      gap_cnt     <= '0;
      send_first  <= 1'b0;
      last_flag   <= 1'b0;
      tx_data     <= '0;
      ack_gnt     <= 1'b0;
      sci_gnt     <= 1'b0;
      ack_rd      <= 1'b0;
      sci_rd      <= 1'b0;
      tx_start    <= 1'b0;
      frame_done  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      ack_rd      <= 1'b0;
      sci_rd      <= 1'b0;
      tx_start    <= 1'b0;
      frame_done  <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          // The grant is registered, so it becomes visible one cycle after arbitration.
          if (ack_req || sci_req) begin
            ack_gnt     <= ack_wins;
            sci_gnt     <= !ack_wins;
            last_winner <= ack_wins ? LW_ACK : LW_SCI;
            byte_cnt    <= '0;
            to_cnt      <= '0;
            state       <= WAITB;
          end
        end
        WAITB: begin
          // A byte arriving on the terminal count wins over the timeout.
          if (src_valid) begin
            tx_data    <= src_data;
            tx_start   <= 1'b1;
            ack_rd     <= ack_gnt;
            sci_rd     <= sci_gnt;
            last_flag  <= ack_gnt && ack_last;
            if (byte_cnt != 9'h1ff) byte_cnt <= byte_cnt + 1'b1;
            to_cnt     <= '0;
            send_first <= 1'b1;
            state      <= SEND;
          end else if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
            timeout_err <= 1'b1;
            ack_gnt     <= 1'b0;
            sci_gnt     <= 1'b0;
            gap_cnt     <= '0;
            state       <= GAP;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        SEND: begin
          // tx_busy only rises the cycle after tx_start, so the first cycle is skipped.
          if (send_first) begin
            send_first <= 1'b0;
          end else if (!tx_busy) begin
            if (frame_end) begin
              frame_done <= 1'b1;
              ack_gnt    <= 1'b0;
              sci_gnt    <= 1'b0;
              gap_cnt    <= '0;
              state      <= GAP;
            end else begin
              state <= WAITB;
            end
          end
        end
        GAP: begin
          if (gap_cnt == GAP_W'(GAP_CYC - 1)) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rs422_tx_arb.sv
// Bench for rs422_tx_arb: timestamp-based frame model checked every cycle, plus directed
// frame, tie, timeout, boundary, reset and gap hold-off scenarios and a random phase.
`timescale 1ns/1ps
module tb_rs422_tx_arb;

  localparam int FRAME_LEN   = 268;
  localparam int GAP_CYC     = 2400;
  localparam int TIMEOUT_CYC = 12000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ack_req = 1'b0, ack_valid = 1'b0, ack_last = 1'b0;
  logic [7:0] ack_data = 8'h00;
  logic       sci_req = 1'b0, sci_valid = 1'b0;
  logic [7:0] sci_data = 8'h00;
  logic       tx_busy = 1'b0;
  logic       ack_gnt, sci_gnt, ack_rd, sci_rd, tx_start, frame_done, timeout_err, reply;
  logic [7:0] tx_data;

  always #5 clk = ~clk;

  rs422_tx_arb #(
    .FRAME_LEN  (FRAME_LEN),
    .GAP_CYC    (GAP_CYC),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst(rst),
    .ack_req(ack_req), .ack_valid(ack_valid), .ack_last(ack_last), .ack_data(ack_data),
    .sci_req(sci_req), .sci_valid(sci_valid), .sci_data(sci_data),
    .ack_gnt(ack_gnt), .sci_gnt(sci_gnt), .ack_rd(ack_rd), .sci_rd(sci_rd),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .frame_done(frame_done), .timeout_err(timeout_err), .reply(reply)
  );

  int     tests = 0;
  int     fails = 0;
  int     nprint = 0;
  longint cyc = 0;
  bit     chk_en = 1'b0;

  // Environment: UART busy timer and the two byte sources.
  int   busy_len = 10, busy_cnt = 0;
  bit   rand_busy = 1'b0;
  int   sci_vprob = 100, ack_vprob = 100;
  int   sci_pops = 0, sci_limit = 1 << 30, ack_left = 0;
  logic p_tx_start = 1'b0, p_ack_rd = 1'b0, p_sci_rd = 1'b0;

  // Frame-level model: owner of the link, bytes sent, and absolute cycle stamps.
  int     m_owner = 0;            // 0 none, 1 ack, 2 sci
  bit     m_lw_ack = 1'b0;
  bit     m_inflight = 1'b0;
  bit     m_last = 1'b0;
  int     m_count = 0;
  longint m_wait_from = 0, m_send_at = 0, m_gap_end = 0;
  logic [7:0] e_tx_data = 8'h00;
  bit     e_ack_rd = 1'b0, e_sci_rd = 1'b0, e_start = 1'b0, e_done = 1'b0, e_to = 1'b0;

  task automatic check(input string name, input longint got, input longint want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // c is the cycle just ended; cyc becomes the cycle whose outputs are predicted.
  task automatic model_step();
    longint c;
    bit     v;
    c = cyc;
    cyc++;
    e_ack_rd = 1'b0; e_sci_rd = 1'b0; e_start = 1'b0; e_done = 1'b0; e_to = 1'b0;
    if (rst) begin
      m_owner = 0; m_lw_ack = 1'b0; m_inflight = 1'b0; m_last = 1'b0;
      m_count = 0; m_gap_end = 0; e_tx_data = 8'h00;
    end else if (m_owner == 0) begin
      if (c >= m_gap_end && (ack_req || sci_req)) begin
        m_owner     = (ack_req && !(sci_req && m_lw_ack)) ? 1 : 2;
        m_lw_ack    = (m_owner == 1);
        m_count     = 0;
        m_inflight  = 1'b0;
        m_wait_from = cyc;
      end
    end else if (!m_inflight) begin
      v = (m_owner == 1) ? ack_valid : sci_valid;
      if (v) begin
        e_tx_data  = (m_owner == 1) ? ack_data : sci_data;
        e_start    = 1'b1;
        e_ack_rd   = (m_owner == 1);
        e_sci_rd   = (m_owner == 2);
        m_last     = (m_owner == 1) && ack_last;
        m_count    = (m_count < 511) ? m_count + 1 : 511;
        m_inflight = 1'b1;
        m_send_at  = cyc;
      end else if (c - m_wait_from == longint'(TIMEOUT_CYC - 1)) begin
        e_to      = 1'b1;
        m_owner   = 0;
        m_gap_end = cyc + GAP_CYC;
      end
    end else if (c > m_send_at && !tx_busy) begin
      if ((m_owner == 2) ? (m_count == FRAME_LEN) : m_last) begin
        e_done    = 1'b1;
        m_owner   = 0;
        m_gap_end = cyc + GAP_CYC;
      end else begin
        m_inflight  = 1'b0;
        m_wait_from = cyc;
      end
    end
    chk_en = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    if (p_tx_start) busy_cnt = rand_busy ? int'($urandom_range(4, 1)) : busy_len;
    else if (busy_cnt > 0) busy_cnt--;
    tx_busy = (busy_cnt > 0);
    if (p_sci_rd) begin sci_pops++; sci_data = 8'($urandom); end
    if (p_ack_rd) begin if (ack_left > 0) ack_left--; ack_data = 8'($urandom); end
    sci_valid = (sci_pops < sci_limit) && (int'($urandom_range(99)) < sci_vprob);
    ack_valid = (ack_left > 0) && (int'($urandom_range(99)) < ack_vprob);
    ack_last  = (ack_left == 1);
    @(negedge clk);
    p_tx_start = tx_start; p_ack_rd = ack_rd; p_sci_rd = sci_rd;
  endtask

  task automatic run_frame(input int bound, output int starts, output int dones,
                           output int tos, output longint last_start, output longint end_cyc);
    starts = 0; dones = 0; tos = 0; last_start = 0; end_cyc = 0;
    for (int k = 0; k < bound; k++) begin
      tick();
      if (tx_start) begin starts++; last_start = cyc; end
      if (frame_done) dones++;
      if (timeout_err) tos++;
      if (frame_done || timeout_err) begin end_cyc = cyc; break; end
    end
  endtask

  task automatic wait_gnt(input string name, input bit want_ack);
    int k;
    for (k = 0; k < 5000 && !(ack_gnt || sci_gnt); k++) tick();
    check(name, longint'({ack_gnt, sci_gnt}), want_ack ? 2 : 1);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 5000 && reply; k++) tick();
  endtask

  // Per-cycle comparison of every output against the model.
  initial begin
    logic [15:0] got, want;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        got  = {ack_gnt, sci_gnt, ack_rd, sci_rd, tx_start, frame_done, timeout_err, reply, tx_data};
        want = {(m_owner == 1), (m_owner == 2), e_ack_rd, e_sci_rd, e_start, e_done, e_to,
                ((m_owner != 0) || (cyc < m_gap_end)), e_tx_data};
        tests++;
        if (got !== want) begin
          fails++;
          if (nprint < 30) begin
            nprint++;
            $display("FAIL cycle_outputs cycle %0d: got %h, expected %h", cyc, got, want);
          end
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int     starts, dones, tos, gg, te, nst, k;
    longint last_start, end_cyc, s;

    // Reset state
    repeat (4) tick();
    check("reset_outputs", longint'({ack_gnt, sci_gnt, ack_rd, sci_rd, tx_start,
                                     frame_done, timeout_err, reply, tx_data}), 0);
    rst = 1'b0;
    tick();

    // Full science frame, request dropped right after grant
    sci_req = 1'b1;
    wait_gnt("sci_grant", 1'b0);
    sci_req = 1'b0;
    run_frame(10000, starts, dones, tos, last_start, end_cyc);
    check("sci_frame_starts", starts, 268);
    check("sci_frame_done", dones, 1);
    check("sci_frame_no_timeout", tos, 0);
    gg = 0;
    while (reply && gg < 5000) begin gg++; tick(); end
    check("gap_reply_cycles", gg, 2400);

    // Tie from reset: ack first, then sci after the gap
    rst = 1'b1; ack_left = 3; ack_vprob = 100; ack_req = 1'b1; sci_req = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    check("tie_ack_first", longint'({ack_gnt, sci_gnt}), 2);
    ack_req = 1'b0;
    run_frame(2000, starts, dones, tos, last_start, end_cyc);
    check("ack_frame_starts", starts, 3);
    check("ack_frame_done", dones, 1);
    for (k = 0; k < 5000 && !sci_gnt; k++) tick();
    check("tie_sci_gnt_delay", k, 2401);
    sci_req = 1'b0;
    run_frame(10000, starts, dones, tos, last_start, end_cyc);
    check("tie_sci_frame_starts", starts, 268);
    wait_idle();

    // Timeout after five bytes
    sci_limit = sci_pops + 5; sci_req = 1'b1;
    wait_gnt("timeout_grant", 1'b0);
    sci_req = 1'b0;
    run_frame(20000, starts, dones, tos, last_start, end_cyc);
    check("timeout_starts", starts, 5);
    check("timeout_pulse", tos, 1);
    check("timeout_no_done", dones, 0);
    check("timeout_latency", end_cyc - last_start, 12012);
    check("timeout_gnt_dropped", longint'({ack_gnt, sci_gnt}), 0);
    wait_idle();

    // Byte arriving on the terminal count is accepted
    sci_limit = sci_pops + 3; sci_req = 1'b1;
    wait_gnt("boundary_grant", 1'b0);
    sci_req = 1'b0;
    nst = 0; s = 0; te = 0;
    for (k = 0; k < 200 && nst < 3; k++) begin
      tick();
      if (tx_start) begin nst++; s = cyc; end
    end
    for (k = 0; k < 13000 && cyc < s + 12010; k++) begin
      tick();
      if (timeout_err) te++;
    end
    sci_limit = 1 << 30;
    tick();
    if (timeout_err) te++;
    tick();
    if (timeout_err) te++;
    check("boundary_accept", longint'(tx_start), 1);
    check("boundary_no_timeout", te, 0);
    nst = 4;

    // Reset in the middle of byte 100, then a fresh frame restarts the count
    for (k = 0; k < 5000 && nst < 100; k++) begin
      tick();
      if (tx_start) nst++;
    end
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_frame_outputs", longint'({ack_gnt, sci_gnt, ack_rd, sci_rd, tx_start,
                                             frame_done, timeout_err, reply, tx_data}), 0);
    sci_req = 1'b1;
    wait_gnt("restart_grant", 1'b0);
    sci_req = 1'b0;
    run_frame(10000, starts, dones, tos, last_start, end_cyc);
    check("restart_frame_starts", starts, 268);
    check("restart_frame_done", dones, 1);

    // Ack request raised during the gap waits for the gap to end
    ack_left = 4; ack_vprob = 60; ack_req = 1'b1; gg = 0;
    for (k = 0; k < 5000 && reply; k++) begin
      if (ack_gnt || sci_gnt) gg++;
      tick();
    end
    check("gap_no_grant", gg, 0);
    tick();
    check("gnt_after_gap", longint'(ack_gnt), 1);
    ack_req = 1'b0;
    run_frame(3000, starts, dones, tos, last_start, end_cyc);
    check("holdoff_ack_starts", starts, 4);
    wait_idle();

    // Random traffic, checked only by the per-cycle model comparison
    rand_busy = 1'b1; sci_vprob = 85; ack_vprob = 85;
    for (int i = 0; i < 15000; i++) begin
      if ($urandom_range(49) == 0) sci_req = ~sci_req;
      if (ack_left == 0) ack_req = 1'b0;
      else if (ack_gnt && $urandom_range(1) == 0) ack_req = 1'b0;
      if (ack_left == 0 && !ack_req && $urandom_range(299) == 0) begin
        ack_left = int'($urandom_range(6, 1));
        ack_req  = 1'b1;
      end
      rst = ($urandom_range(3999) == 0);
      tick();
    end
    rst = 1'b0; sci_req = 1'b0; ack_req = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rs422_tx_arb.md
RS422_TX_ARB -- requirements
Module: rs422_tx_arb

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 268: bytes per science frame (1..511).
REQ-002 SHALL have parameter GAP_CYC, default 2400: idle cycles between frames (200 us at 12 MHz).
REQ-003 SHALL have parameter TIMEOUT_CYC, default 12000: maximum wait for the next byte (1 ms).
REQ-004 SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have ports ack_req, ack_valid, ack_last, input, 1 each: reply-source frame request, byte available, and last byte of the frame.
REQ-007 SHALL have port ack_data, input, 8: reply-source byte.
REQ-008 SHALL have ports sci_req, sci_valid, input, 1 each: science-source frame request and byte available.
REQ-009 SHALL have port sci_data, input, 8: science-source byte.
REQ-010 SHALL have ports ack_gnt, sci_gnt, output, 1 each: grant level for each source.
REQ-011 SHALL have ports ack_rd, sci_rd, output, 1 each: one-cycle byte pop strobe to each source.
REQ-012 SHALL have port tx_data, output, 8: byte to the UART transmitter.
REQ-013 SHALL have port tx_start, output, 1: one-cycle UART start strobe.
REQ-014 SHALL have port tx_busy, input, 1: UART busy flag; it rises the cycle after tx_start.
REQ-015 SHALL have ports frame_done, timeout_err, output, 1 each: one-cycle status pulses.
REQ-016 SHALL have port reply, output, 1: high while a frame or its gap is in progress.

Function
REQ-017 SHALL implement the states IDLE, WAITB, SEND and GAP, with a registered last_winner flag.
REQ-018 In IDLE, the block SHALL apply arbitration when any request is high:
- Ack has priority.
- If both requests are high and last_winner=ACK, sci wins.
- The winner's grant is set and last_winner is updated.
- Next state is WAITB.
- Byte count and timeout count are cleared.
REQ-019 In WAITB, when the granted source's valid=1, on one edge the block SHALL:
- Register tx_data from that source.
- Pulse tx_start and the source's rd.
- Increment byte_cnt.
- Clear the timeout counter.
- Move to SEND.
REQ-020 In SEND, the block SHALL ignore tx_busy for the first cycle, then wait for tx_busy=0, then decide the frame end:
- Frame end for sci: byte_cnt==FRAME_LEN.
- Frame end for ack: the last sent byte carried ack_last=1 (latched at pop).
- At frame end: go to GAP.
- Otherwise: return to WAITB.
REQ-021 In WAITB with valid=0, the timeout counter SHALL increment, and when it reaches TIMEOUT_CYC-1:
- Pulse timeout_err.
- Go to GAP.
REQ-022 On entry to GAP, the block SHALL drop both grants; frame_done SHALL pulse only on a normal completion, not on a timeout.
REQ-023 GAP SHALL last exactly GAP_CYC cycles, then return to IDLE; requests during GAP SHALL be ignored.
REQ-024 reply SHALL equal 1 in the states WAITB, SEND and GAP, and 0 in IDLE.
REQ-025 Deasserting a request mid-frame SHALL have no effect; the frame completes or times out.
REQ-026 Valid and a timeout terminal count in the same cycle SHALL resolve as the byte being accepted, with no timeout.
REQ-027 The ungranted source's rd SHALL never pulse, and tx_start SHALL pulse at most once per SEND.
REQ-028 Counter widths: byte_cnt 9 bits; the gap and timeout counters sized by clog2 of their parameters; no counter wraps.

Reset
REQ-029 While rst=1 the block SHALL hold the following values:
- State IDLE, last_winner=SCI.
- All counters 0.
- tx_data=0.
- All outputs 0.
REQ-030 Asserting rst mid-frame or mid-gap SHALL return the block to the reset state on the next edge, with no frame_done or timeout_err pulse.

Verification
REQ-031 Science frame: sci_req=1 with sci_valid always 1 and the UART busy for 10 cycles per byte -> 268 tx_start pulses, frame_done one cycle, reply high until 2400 cycles later.
REQ-032 Tie: ack_req and sci_req both 1 from reset -> ack granted first (3-byte ack frame, ack_last on byte 3), then sci granted after the gap.
REQ-033 Timeout: sci granted, sci_valid stuck at 0 after byte 5 -> timeout_err exactly 12000 cycles after entering WAITB, no frame_done, grant dropped.
REQ-034 Boundary: sci_valid rises on the timeout terminal cycle -> byte accepted, no timeout_err.
REQ-035 Reset: rst pulsed during byte 100 of a science frame -> all outputs 0 next cycle, and a new sci_req restarts byte_cnt from 1.
REQ-036 Gap hold-off: ack_req asserted during GAP -> no grant until GAP completes, then ack_gnt on the first IDLE cycle.
